// File: rtl/aes_round_ctrl_pkg.sv
// Shared constants, state/register types and the round-key index helper for the AES
// round sequencer.
package aes_round_ctrl_pkg;

  localparam int unsigned Nb          = 4;
  localparam int unsigned Nr          = 10;
  localparam int unsigned Nk          = 4;
  localparam int unsigned KexpTimeout = 64;

  localparam int unsigned Rkw  = $clog2(Nb * (Nr + 1));
  localparam int unsigned RndW = $clog2(Nr + 1);
  localparam int unsigned TmoW = $clog2(KexpTimeout + 1);

  typedef enum logic [2:0] {
    StIdle,
    StKexp,
    StReady,
    StRound,
    StDone
  } ctrl_state_e;

  typedef struct packed {
    ctrl_state_e     state;
    logic [RndW-1:0] round;
    logic [TmoW-1:0] tmo;
    logic            decrypt;
    logic            key_loaded;
    logic            err;
  } reg_t;

  typedef struct packed {
    logic           key_ready;
    logic           in_ready;
    logic           kexp_enable;
    logic           rnd_valid;
    logic           rnd_first;
    logic           rnd_last;
    logic           rnd_decrypt;
    logic [Rkw-1:0] rnd_kidx;
    logic           out_valid;
  } out_t;

  // Decryption walks the expanded key schedule backwards.
  function automatic logic [Rkw-1:0] kidx(input logic [RndW-1:0] rnd, input logic dec);
    logic [RndW-1:0] step;
    step = dec ? RndW'(Nr) - rnd : rnd;
    return Rkw'(step) * Rkw'(Nb);
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Host, key-expansion and round-datapath handshake bundle of the AES round sequencer.
interface aes_round_ctrl_if;

  logic                                key_valid;
  logic                                key_ready;
  logic                                in_valid;
  logic                                in_decrypt;
  logic                                in_ready;
  logic                                kexp_enable;
  logic                                kexp_done;
  logic                                rnd_valid;
  logic                                rnd_first;
  logic                                rnd_last;
  logic                                rnd_decrypt;
  logic [aes_round_ctrl_pkg::Rkw-1:0] rnd_kidx;
  logic                                out_valid;
  logic                                out_ready;
  logic                                key_loaded;
  logic                                kexp_err;

  modport slave (
    input  key_valid, in_valid, in_decrypt, kexp_done, out_ready,
    output key_ready, in_ready, kexp_enable, rnd_valid, rnd_first, rnd_last, rnd_decrypt,
           rnd_kidx, out_valid, key_loaded, kexp_err
  );

  modport master (
    output key_valid, in_valid, in_decrypt, kexp_done, out_ready,
    input  key_ready, in_ready, kexp_enable, rnd_valid, rnd_first, rnd_last, rnd_decrypt,
           rnd_kidx, out_valid, key_loaded, kexp_err
  );

endinterface

// File: rtl/aes_round_ctrl.sv
// Sequencer between host requests and the AES key-expansion engine / round datapath:
// loads keys, then issues one round command per cycle for each accepted block.
module aes_round_ctrl
  import aes_round_ctrl_pkg::*;
(
  input logic             clk,
  input logic             rst,
  aes_round_ctrl_if.slave bus
);

  reg_t r_q, r_d;
  out_t o_q, o_d;

  logic key_acc;
  logic blk_acc;
  logic in_ready_gated;

  // A pending key request takes priority, so block acceptance is withdrawn that cycle.
  assign in_ready_gated = o_q.in_ready & ~bus.key_valid;
  assign key_acc        = bus.key_valid & o_q.key_ready;
  assign blk_acc        = bus.in_valid & in_ready_gated;

  always_comb begin
    r_d = r_q;
    unique case (r_q.state)
      StIdle, StReady: begin
        if (key_acc) begin
          r_d.state      = StKexp;
          r_d.tmo        = '0;
          r_d.key_loaded = 1'b0;
          r_d.err        = 1'b0;
        end else if (blk_acc) begin
          r_d.state   = StRound;
          r_d.round   = '0;
          r_d.decrypt = bus.in_decrypt;
        end
      end
      StKexp: begin
        if (bus.kexp_done) begin
          r_d.state      = StReady;
          r_d.key_loaded = 1'b1;
        end else if (r_q.tmo == TmoW'(KexpTimeout - 1)) begin
          r_d.state      = StIdle;
          r_d.err        = 1'b1;
          r_d.key_loaded = 1'b0;
        end else if (r_q.tmo != '1) begin
          r_d.tmo = r_q.tmo + 1'b1;
        end
      end
      StRound: begin
        if (r_q.round == RndW'(Nr)) begin
          r_d.state = StDone;
        end else begin
          r_d.round = r_q.round + 1'b1;
        end
      end
      StDone: begin
        if (o_q.out_valid && bus.out_ready) begin
          r_d.state = StReady;
        end
      end
      default: r_d.state = StIdle;
    endcase
  end

  // Outputs are a registered decode of the next state, so they track the state flops.
  always_comb begin
    o_d             = '0;
    o_d.key_ready   = (r_d.state == StIdle) || (r_d.state == StReady);
    o_d.in_ready    = (r_d.state == StReady);
    o_d.kexp_enable = key_acc;
    o_d.out_valid   = (r_d.state == StDone);
    if (r_d.state == StRound) begin
      o_d.rnd_valid   = 1'b1;
      o_d.rnd_first   = (r_d.round == '0);
      o_d.rnd_last    = (r_d.round == RndW'(Nr));
      o_d.rnd_decrypt = r_d.decrypt;
      o_d.rnd_kidx    = kidx(r_d.round, r_d.decrypt);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
      o_q <= '0;
    end else begin
      r_q <= r_d;
      o_q <= o_d;
    end
  end

  assign bus.key_ready   = o_q.key_ready;
  assign bus.in_ready    = in_ready_gated;
  assign bus.kexp_enable = o_q.kexp_enable;
  assign bus.rnd_valid   = o_q.rnd_valid;
  assign bus.rnd_first   = o_q.rnd_first;
  assign bus.rnd_last    = o_q.rnd_last;
  assign bus.rnd_decrypt = o_q.rnd_decrypt;
  assign bus.rnd_kidx    = o_q.rnd_kidx;
  assign bus.out_valid   = o_q.out_valid;
  assign bus.key_loaded  = r_q.key_loaded;
  assign bus.kexp_err    = r_q.err;

endmodule
